// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//   Queues ALU results ahead of register-file writeback. Each accepted result
//   ({alu_out, in_dest, in_write}) goes into a small circular buffer and
//   leaves in arrival order on the wb_* handshake. The status register
//   {N,V,Z} is loaded when the result is accepted, not when it is written
//   back, so flag consumers see the update one cycle after the transfer.
//
//   Optional feature macro: ALU_RESULT_BYPASS_EN
//     When defined, an empty queue with in_valid=1 and wb_ready=1 forwards
//     the input straight to wb_* in the same cycle without enqueuing it.
//     When undefined, wb_* are driven only from registered queue state.
//
// Parameters
//   DEPTH     number of queue entries (power of two, 2..8)
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_valid  ALU result present          in_ready  stage can accept
//   alu_out   ALU result (16)             Z, V, N   ALU flags
//   in_dest   destination register (3)    in_write  result goes to regfile
//   in_loads  flags load status register
//   wb_valid  writeback entry available   wb_ready  regfile consumes entry
//   wb_data   writeback data (16)         wb_dest   writeback register (3)
//   wb_write  regfile write qualifier     status    status register {N,V,Z}
//   count     occupied entries (4)
// -----------------------------------------------------------------------------
module alu_result_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] alu_out,
    input  logic        Z,
    input  logic        V,
    input  logic        N,
    input  logic [2:0]  in_dest,
    input  logic        in_write,
    input  logic        in_loads,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_dest,
    output logic        wb_write,
    output logic [2:0]  status,
    output logic [3:0]  count
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [15:0]   r_data  [DEPTH];
    logic [2:0]    r_dest  [DEPTH];
    logic          r_write [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [3:0]    r_count;
    logic [2:0]    r_status;

    logic w_nonempty;
    logic w_in_fire;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_nonempty = (r_count != 4'd0);

    // A full queue still accepts when the head is leaving on the same edge.
    // Gating with rst_n keeps in_ready low for the whole reset window.
    assign in_ready  = rst_n && ((r_count < DEPTH_C) || wb_ready);
    assign w_in_fire = in_valid && in_ready;

`ifdef ALU_RESULT_BYPASS_EN
    // Empty queue and a consumer ready: hand the result straight through.
    assign w_bypass = rst_n && !w_nonempty && in_valid && wb_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_in_fire && !w_bypass;
    assign w_pop  = w_nonempty && wb_ready;

    // Storage needs no reset: an entry is only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wptr]  <= alu_out;
            r_dest[r_wptr]  <= in_dest;
            r_write[r_wptr] <= in_write;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 4'd0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Flags follow acceptance, independent of writeback timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= 3'b000;
        end else if (w_in_fire && in_loads) begin
            r_status <= {N, V, Z};
        end
    end

    always_comb begin
        wb_valid = 1'b0;
        wb_data  = 16'h0000;
        wb_dest  = 3'b000;
        wb_write = 1'b0;
        if (w_nonempty) begin
            wb_valid = 1'b1;
            wb_data  = r_data[r_rptr];
            wb_dest  = r_dest[r_rptr];
            wb_write = r_write[r_rptr];
        end else if (w_bypass) begin
            wb_valid = 1'b1;
            wb_data  = alu_out;
            wb_dest  = in_dest;
            wb_write = in_write;
        end
    end

    assign status = r_status;
    assign count  = r_count;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

`ifdef ALU_RESULT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, Z, V, N, in_write, in_loads, wb_ready;
    logic [15:0] alu_out;
    logic [2:0]  in_dest;

    logic        rdy [2];
    logic        wbv [2];
    logic [15:0] wbd [2];
    logic [2:0]  wbdst [2];
    logic        wbw [2];
    logic [2:0]  st [2];
    logic [3:0]  cnt [2];

    alu_result_stage #(.DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .alu_out(alu_out), .Z(Z), .V(V), .N(N), .in_dest(in_dest),
        .in_write(in_write), .in_loads(in_loads), .wb_valid(wbv[0]),
        .wb_ready(wb_ready), .wb_data(wbd[0]), .wb_dest(wbdst[0]),
        .wb_write(wbw[0]), .status(st[0]), .count(cnt[0]));

    alu_result_stage #(.DEPTH(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .alu_out(alu_out), .Z(Z), .V(V), .N(N), .in_dest(in_dest),
        .in_write(in_write), .in_loads(in_loads), .wb_valid(wbv[1]),
        .wb_ready(wb_ready), .wb_data(wbd[1]), .wb_dest(wbdst[1]),
        .wb_write(wbw[1]), .status(st[1]), .count(cnt[1]));

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of pending results per DUT.
    int          dep [2] = '{2, 4};
    logic [19:0] mq  [2][8];
    int          mn  [2];
    logic [2:0]  mst [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            mn[k]  = 0;
            mst[k] = 3'b000;
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s d%0d count", tag, dep[k]), 32'(cnt[k]), 0);
            chk($sformatf("%s d%0d wb_valid", tag, dep[k]), 32'(wbv[k]), 0);
            chk($sformatf("%s d%0d status", tag, dep[k]), 32'(st[k]), 0);
            chk($sformatf("%s d%0d in_ready", tag, dep[k]), 32'(rdy[k]), 0);
        end
    endtask

    // One clock: check all outputs against the model, take the edge, update.
    task automatic step(input string tag);
        bit          acc [2];
        bit          byp [2];
        bit          pop [2];
        bit          erdy, ewbv;
        logic [19:0] ehead;
        #1;
        for (int k = 0; k < 2; k++) begin
            erdy   = rst_n && ((mn[k] < dep[k]) || wb_ready);
            byp[k] = BYP && rst_n && (mn[k] == 0) && in_valid && wb_ready;
            ewbv   = (mn[k] != 0) || byp[k];
            ehead  = (mn[k] != 0) ? mq[k][0] :
                     byp[k] ? {alu_out, in_dest, in_write} : 20'h0;
            chk($sformatf("%s d%0d in_ready", tag, dep[k]), 32'(rdy[k]), 32'(erdy));
            chk($sformatf("%s d%0d wb_valid", tag, dep[k]), 32'(wbv[k]), 32'(ewbv));
            chk($sformatf("%s d%0d wb_data", tag, dep[k]), 32'(wbd[k]), 32'(ehead[19:4]));
            chk($sformatf("%s d%0d wb_dest", tag, dep[k]), 32'(wbdst[k]), 32'(ehead[3:1]));
            chk($sformatf("%s d%0d wb_write", tag, dep[k]), 32'(wbw[k]), 32'(ehead[0]));
            chk($sformatf("%s d%0d count", tag, dep[k]), 32'(cnt[k]), 32'(mn[k]));
            chk($sformatf("%s d%0d status", tag, dep[k]), 32'(st[k]), 32'(mst[k]));
            acc[k] = in_valid && erdy;
            pop[k] = (mn[k] != 0) && wb_ready;
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (acc[k] && in_loads) mst[k] = {N, V, Z};
            if (!byp[k]) begin
                if (pop[k]) begin
                    for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
                    mn[k]--;
                end
                if (acc[k]) begin
                    mq[k][mn[k]] = {alu_out, in_dest, in_write};
                    mn[k]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [15:0] d, input logic [2:0] dst,
                         input bit w, input bit ld, input logic [2:0] nvz, input bit rdy_in);
        in_valid = v;  alu_out = d;  in_dest = dst;  in_write = w;
        in_loads = ld; {N, V, Z} = nvz; wb_ready = rdy_in;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 16'h0, 3'd0, 0, 0, 3'b000, 0);
        model_clear();
        #2;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First cycle out of reset: ready, empty.
        drive(0, 16'h0, 3'd0, 0, 0, 3'b000, 1);
        step("post_reset");

        // Single result, consumer ready.
        drive(1, 16'h0005, 3'd3, 1, 0, 3'b000, 1);
        step("push5");
        drive(0, 16'h0, 3'd0, 0, 0, 3'b000, 1);
`ifndef ALU_RESULT_BYPASS_EN
        #1;
        chk("push5 wb_data", 32'(wbd[0]), 32'h5);
        chk("push5 wb_dest", 32'(wbdst[0]), 32'd3);
        chk("push5 wb_write", 32'(wbw[0]), 32'd1);
`endif
        step("drain5");

        // Back-pressure: three pushes into DEPTH=2, third dropped.
        drive(1, 16'h0001, 3'd1, 1, 0, 3'b000, 0); step("bp1");
        drive(1, 16'h0002, 3'd2, 0, 0, 3'b000, 0); step("bp2");
        drive(1, 16'h0003, 3'd3, 1, 0, 3'b000, 0); step("bp3");
        drive(0, 16'h0, 3'd0, 0, 0, 3'b000, 0);
        #1;
        chk("bp full count", 32'(cnt[0]), 32'd2);
        chk("bp full in_ready", 32'(rdy[0]), 32'd0);
        wb_ready = 1'b1;
        #1;
        chk("bp head1", 32'(wbd[0]), 32'h1);
        step("bp pop1");
        #1;
        chk("bp head2", 32'(wbd[0]), 32'h2);

        // Full queue with simultaneous pop still accepts.
        drive(1, 16'h0011, 3'd4, 1, 0, 3'b000, 0); step("fill");
        drive(1, 16'h00AA, 3'd5, 1, 0, 3'b000, 1);
        #1;
        chk("full+pop in_ready", 32'(rdy[0]), 32'd1);
        step("push_aa");
        chk("full+pop count", 32'(cnt[0]), 32'd2);
        drive(0, 16'h0, 3'd0, 0, 0, 3'b000, 1);
        for (int i = 0; i < 4; i++) step("drain_aa");

        // Status loads only with in_loads.
        drive(1, 16'h0000, 3'd0, 0, 1, 3'b001, 1); step("st_load");
        drive(1, 16'h8000, 3'd0, 0, 0, 3'b100, 1); step("st_hold");
        chk("status d2", 32'(st[0]), 32'b001);
        chk("status d4", 32'(st[1]), 32'b001);
        drive(0, 16'h0, 3'd0, 0, 0, 3'b000, 1);
        for (int i = 0; i < 3; i++) step("st_drain");

        // Random traffic; enough pops on DEPTH=4 to wrap its pointers repeatedly.
        for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(0, 3) != 0), 16'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0));
            step("rand");
        end
        drive(0, 16'h0, 3'd0, 0, 0, 3'b000, 1);
        for (int i = 0; i < 5; i++) step("rand_drain");

        // Reset mid-operation with two entries queued and nonzero status.
        drive(1, 16'h1234, 3'd6, 1, 1, 3'b111, 0); step("pre_rst1");
        drive(1, 16'h5678, 3'd7, 1, 1, 3'b110, 0); step("pre_rst2");
        chk("pre_rst count", 32'(cnt[0]), 32'd2);
        drive(0, 16'h0, 3'd0, 0, 0, 3'b000, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("mid_reset");
        model_clear();
        @(posedge clk);
        #1;
        chk_reset("mid_reset_edge");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("post_mid_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The module SHALL have a parameter DEPTH, default 2, giving the number of result-queue entries (power of two, 2..8).
REQ-002 The module SHALL have a port clk, input, 1, the single clock; every flop updates on its rising edge.
REQ-003 The module SHALL have a port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 The module SHALL have a port in_valid, input, 1, meaning ALU result present this cycle.
REQ-005 The module SHALL have a port in_ready, output, 1, meaning the stage can accept a result.
REQ-006 The module SHALL have a port alu_out, input, 16, the ALU result.
REQ-007 The module SHALL have ports Z, V and N, inputs, 1 each, the ALU zero, overflow and negative flags.
REQ-008 The module SHALL have a port in_dest, input, 3, the destination register index.
REQ-009 The module SHALL have a port in_write, input, 1, meaning the result is written to the register file.
REQ-010 The module SHALL have a port in_loads, input, 1, meaning the flags update the status register.
REQ-011 The module SHALL have a port wb_valid, output, 1, meaning a writeback entry is available.
REQ-012 The module SHALL have a port wb_ready, input, 1, meaning the register file consumes the entry.
REQ-013 The module SHALL have a port wb_data, output, 16, the writeback data.
REQ-014 The module SHALL have a port wb_dest, output, 3, the writeback register index.
REQ-015 The module SHALL have a port wb_write, output, 1, the register-file write strobe qualifier.
REQ-016 The module SHALL have a port status, output, 3, the status register {N,V,Z}.
REQ-017 The module SHALL have a port count, output, 4, the number of occupied queue entries.

Function
REQ-018 An input transfer SHALL occur on a rising clk edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on an edge with wb_valid=1 and wb_ready=1.
REQ-019 in_ready SHALL be 1 when count<DEPTH, or when count==DEPTH and wb_ready=1 (simultaneous pop frees a slot).
REQ-020 Each input transfer SHALL enqueue {alu_out, in_dest, in_write} in a circular buffer with wrapping read/write pointers; entries SHALL leave in arrival order.
REQ-021 wb_valid SHALL equal (count!=0); wb_data, wb_dest and wb_write SHALL come from the head entry.
REQ-022 When wb_valid=0, wb_data SHALL be 16'h0000, wb_dest 3'b000, and wb_write 0.
REQ-023 count SHALL increment on push only, decrement on pop only, and stay unchanged on simultaneous push and pop, including at count==DEPTH.
REQ-024 A push with in_ready=0 SHALL be ignored and SHALL NOT corrupt any entry or pointer.
REQ-025 The status register SHALL load {N,V,Z} on the edge of an input transfer with in_loads=1, and SHALL hold otherwise.
REQ-026 A status update SHALL be visible in the cycle after the transfer, independent of when the entry is written back.
REQ-027 Entries with in_write=0 SHALL still occupy a slot and be popped, so that ordering is preserved.
REQ-028 Queue latency SHALL be 1 cycle: data pushed at edge k SHALL be presentable on wb_* after edge k.

Reset
REQ-029 While rst_n=0, regardless of clk, the module SHALL hold count=0, both pointers=0, status=3'b000, wb_valid=0 and in_ready=0.
REQ-030 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries with no writeback.

Configuration
REQ-032 With macro ALU_RESULT_BYPASS_EN defined, when count==0, in_valid=1 and wb_ready=1, the input SHALL pass combinationally to wb_* with wb_valid=1 in the same cycle, without enqueuing; the status register SHALL still update per REQ-025.
REQ-033 Without ALU_RESULT_BYPASS_EN, no combinational path SHALL exist from the in_* ports to the wb_* ports, and latency SHALL always be 1 cycle.

Verification
REQ-034 The bench SHALL push alu_out=16'h0005 with in_dest=3, in_write=1 and wb_ready=1 -> next cycle wb_data=16'h0005, wb_dest=3, wb_write=1 (same cycle if ALU_RESULT_BYPASS_EN).
REQ-035 The bench SHALL hold wb_ready=0 and push 16'h0001, 16'h0002, 16'h0003 with DEPTH=2 -> count=2, in_ready=0, third push ignored; then release wb_ready -> outputs 1 then 2.
REQ-036 With count==DEPTH and wb_ready=1, the bench SHALL push 16'h00AA -> in_ready=1, count stays 2, and 16'h00AA later emerges in order.
REQ-037 The bench SHALL push with in_loads=1, Z=1, V=0, N=0, then push with in_loads=0, N=1 -> status=3'b001 after both.
REQ-038 The bench SHALL run 20 cycles of random push/pop with DEPTH=4 -> output sequence equals input sequence, pointers wrap at least twice, and count matches the model.
REQ-039 The bench SHALL assert rst_n=0 between clock edges with count=2 -> count=0, wb_valid=0 and status=0 immediately, with no writeback occurring.
